// File: rtl/vram_arbiter.sv
// ---------------------------------------------------------------------------
// vram_arbiter
//   Shares the VRAM block RAM (1-cycle registered read) between the video
//   fetch engine and the CPU MMIO bus. Video owns the read port whenever it
//   asks. The bus uses the read port only in free cycles and alone owns the
//   write port. Byte-strobed bus writes are done as read-modify-write.
//
// Ports
//   clk, reset                  pixel clock, async active-high reset
//   vid_req/vid_addr            video fetch request, one word per cycle
//   vid_valid/vid_rdata         video data, fixed 2 cycles after vid_req
//   bus_sel/bus_wstrb/bus_addr/bus_wdata
//                               bus transaction, held until bus_ready
//   bus_ready/bus_rdata         completion pulse and read data (held)
//   ram_ren/ram_raddr/ram_rdata RAM read port
//   ram_wen/ram_waddr/ram_wdata RAM write port
//   stall_cnt                   saturating count of bus read-port losses
// ---------------------------------------------------------------------------
module vram_arbiter #(
  parameter int AW      = 12,
  parameter int DW      = 16,
  parameter int STALL_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               vid_req,
  input  logic [AW-1:0]      vid_addr,
  output logic               vid_valid,
  output logic [DW-1:0]      vid_rdata,
  input  logic               bus_sel,
  input  logic [1:0]         bus_wstrb,
  input  logic [AW-1:0]      bus_addr,
  input  logic [DW-1:0]      bus_wdata,
  output logic               bus_ready,
  output logic [DW-1:0]      bus_rdata,
  output logic               ram_ren,
  output logic [AW-1:0]      ram_raddr,
  input  logic [DW-1:0]      ram_rdata,
  output logic               ram_wen,
  output logic [AW-1:0]      ram_waddr,
  output logic [DW-1:0]      ram_wdata,
  output logic [STALL_W-1:0] stall_cnt
);

  localparam int LW = DW / 2;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RD   = 3'd1;
  localparam logic [2:0] S_RDW  = 3'd2;
  localparam logic [2:0] S_MRG  = 3'd3;
  localparam logic [2:0] S_WR   = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;
  localparam logic [2:0] S_HOLD = 3'd6;

  logic [2:0]    state;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] data_q;   // write data, replaced by the merged word in MRG
  logic [1:0]    wstrb_q;
  logic          vid_pipe; // video read issued last cycle, data lands next

  // The bus claims the read port only in a cycle video leaves free.
  logic bus_claim;
  logic bus_stall;
  assign bus_claim = (state == S_RD) && bus_sel && !vid_req;
  assign bus_stall = (state == S_RD) && bus_sel &&  vid_req;

  // NOTE: state and every register that feeds an output are reset, so all
  // outputs read 0 while reset is held and an abandoned transaction leaves
  // nothing behind.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      addr_q    <= '0;
      data_q    <= '0;
      wstrb_q   <= '0;
      vid_pipe  <= 1'b0;
      vid_valid <= 1'b0;
      ram_ren   <= 1'b0;
      ram_raddr <= '0;
      bus_rdata <= '0;
      stall_cnt <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every register here
      // sees the values from before this edge regardless of statement order.
      ram_ren   <= vid_req | bus_claim;
      ram_raddr <= vid_req ? vid_addr : addr_q;
      vid_pipe  <= vid_req;
      vid_valid <= vid_pipe;

      if (bus_stall && (stall_cnt != '1))
        stall_cnt <= stall_cnt + STALL_W'(1);

      case (state)
        S_IDLE: if (bus_sel) begin
          addr_q  <= bus_addr;
          data_q  <= bus_wdata;
          wstrb_q <= bus_wstrb;
          state   <= (bus_wstrb == 2'b11) ? S_WR : S_RD;
        end
        S_RD: begin
          if (!bus_sel)       state <= S_IDLE;
          else if (bus_claim) state <= S_RDW;
        end
        S_RDW: state <= bus_sel ? S_MRG : S_IDLE;
        S_MRG: begin
          if (!bus_sel) begin
            state <= S_IDLE;
          end else if (wstrb_q == 2'b00) begin
            bus_rdata <= ram_rdata;
            state     <= S_DONE;
          end else begin
            data_q[LW-1:0]  <= wstrb_q[0] ? data_q[LW-1:0]  : ram_rdata[LW-1:0];
            data_q[DW-1:LW] <= wstrb_q[1] ? data_q[DW-1:LW] : ram_rdata[DW-1:LW];
            state           <= S_WR;
          end
        end
        // Once WR is reached the write completes even if bus_sel drops.
        S_WR:    state <= S_DONE;
        S_DONE:  state <= S_HOLD;
        S_HOLD:  if (!bus_sel) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus_ready = (state == S_DONE);
  assign ram_wen   = (state == S_WR);
  assign ram_waddr = addr_q;
  assign ram_wdata = data_q;
  // Gated by vid_valid so the output is 0 in reset and between fetches.
  assign vid_rdata = vid_valid ? ram_rdata : '0;

endmodule

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
- Sequences the shared VRAM dual-port block RAM (16-bit data, 4096 words, 1-cycle registered read) between two requesters: the video text/graphics fetch engine and the CPU MMIO bus.
- Video fetch has absolute priority on the RAM read port. The bus gets the read port only in free cycles. The bus alone owns the write port.
- Byte-strobed bus writes are done as read-modify-write. This replaces ad-hoc pixel-phase muxing of RAM reads in the display core.

Parameters:
AW, 12, RAM word address width
DW, 16, RAM data width (2 byte lanes)
STALL_W, 8, width of saturating bus-stall counter

Ports:
clk  in  1  pixel clock; all logic on rising edge
reset  in  1  asynchronous, active-high reset
vid_req  in  1  video fetch request, one cycle per word
vid_addr  in  AW  video fetch word address
vid_valid  out  1  video read data valid
vid_rdata  out  DW  video read data (direct from ram_rdata)
bus_sel  in  1  bus transaction active; held until bus_ready
bus_wstrb  in  2  byte strobes; 00 = read
bus_addr  in  AW  bus word address
bus_wdata  in  DW  bus write data
bus_ready  out  1  one-cycle transaction-complete pulse
bus_rdata  out  DW  bus read data, valid with bus_ready, held after
ram_ren  out  1  RAM read enable
ram_raddr  out  AW  RAM read address
ram_rdata  in  DW  RAM read data (1 cycle after ren)
ram_wen  out  1  RAM write enable
ram_waddr  out  AW  RAM write address
ram_wdata  out  DW  RAM write data
stall_cnt  out  STALL_W  saturating count of cycles the bus lost the read port

Behaviour:
- Reset (async, while reset=1): all outputs are 0, FSM is in IDLE, and the video pipe flag is cleared. Reset asserted mid-transaction abandons it: no write is issued, and bus_ready stays 0 until a fresh bus_sel.
- Read-port registers (ram_ren, ram_raddr) update on each clk edge.
- Video path:
  - vid_req=1 in cycle t → ram_ren=1, ram_raddr=vid_addr in cycle t+1 → vid_valid=1 in cycle t+2 with vid_rdata=ram_rdata.
  - Fixed 2-cycle latency. Back-to-back vid_req is legal every cycle.
- Bus FSM states: IDLE, RD, RDW, MRG, WR, DONE, HOLD.
  - IDLE: if bus_sel, latch addr/wdata/wstrb. Go to WR if wstrb==11, otherwise RD.
  - RD: claim the read port only if vid_req=0 this cycle. If claimed → RDW. If not, stay in RD and increment stall_cnt (saturates at all-ones, never wraps).
  - RDW: read is in flight; next state MRG.
  - MRG: capture ram_rdata.
    - Read (wstrb==00): bus_rdata=ram_rdata → DONE.
    - Partial write: merge per lane (lane0=wdata[7:0] if wstrb[0], else rdata[7:0]; lane1 likewise) → WR.
  - WR: ram_wen=1 for exactly one cycle with the latched/merged address and data → DONE. The write port is never contended, so WR takes no stall.
  - DONE: bus_ready=1 for one cycle → HOLD.
  - HOLD: wait for bus_sel=0 → IDLE. No new transaction starts while bus_sel remains high.
- Abort: bus_sel falling in RD, RDW or MRG returns the FSM to IDLE with no write and no bus_ready. Once WR is entered, the write completes.
- Latency with no contention:
  - Read: 4 cycles from IDLE to bus_ready.
  - Full write: 2 cycles.
  - Partial write: 5 cycles.
- Collisions:
  - A bus write and a video read to the same address in the same cycle is legal; video gets the old data (read-before-write).
  - RMW atomicity against other bus masters is not required (single bus).
- stall_cnt is cleared only by reset.

Test Plan:
- Video stream: vid_req=1 for 8 cycles, addresses 0x010–0x017, RAM preloaded addr+0x1000 → vid_valid high cycles 2–9 with rdata 0x1010…0x1017 in order.
- Bus read under contention: bus read addr 0x123 (RAM=0xBEEF) while vid_req is high for 5 cycles → bus_ready delayed by 5, bus_rdata=0xBEEF, stall_cnt=5, video data unaffected.
- Partial write: RAM[0x040]=0x1234, bus_wstrb=01, wdata=0xAB → one ram_wen with wdata=0x12AB; next read returns 0x12AB. wstrb=10, wdata=0xCD00 → 0xCDAB.
- Full write: wstrb=11, wdata=0x5A5A, addr 0xFFF → no ram_ren from the bus, ram_wen in cycle 1, bus_ready in cycle 2; address wraps nothing.
- Abort/reset: bus_sel dropped in RDW → no ram_wen, no bus_ready. Reset pulsed during WR-bound partial write → all outputs 0 and the next transaction completes normally.
- Saturation: hold vid_req=1 for 300 cycles with a pending bus read → stall_cnt=255, and the bus completes 4 cycles after vid_req drops.
